// File: rtl/store_rmw_pkg.sv
// Shared encodings for the store read-modify-write block: store selects,
// FSM states and the word-read load-select constant.
package store_rmw_pkg;

    localparam logic [1:0] SEL_SW  = 2'b00;
    localparam logic [1:0] SEL_SB  = 2'b01;
    localparam logic [1:0] SEL_SH  = 2'b10;
    localparam logic [1:0] SEL_RSV = 2'b11;

    localparam logic [3:0] LOADSEL_WORD = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10
    } state_e;

    // Sub-word stores must fetch the old word before merging.
    function automatic logic sel_needs_read(input logic [1:0] sel);
        return (sel == SEL_SB) || (sel == SEL_SH);
    endfunction

endpackage

// File: rtl/store_rmw_if.sv
// Store request channel plus data-memory port of store_rmw.
// The slave modport is the store_rmw side; master is requester plus memory.
interface store_rmw_if #(
    parameter int DM_WORDS = 128
);
    localparam int AW = $clog2(DM_WORDS);

    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_sel;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_din;
    logic [3:0]    dm_loadsel;
    logic [31:0]   dm_rdata;
    logic          done;
    logic          err;

    modport master (
        output req_valid, req_sel, req_addr, req_wdata, dm_rdata,
        input  req_ready, dm_wr, dm_addr, dm_din, dm_loadsel, done, err
    );

    modport slave (
        input  req_valid, req_sel, req_addr, req_wdata, dm_rdata,
        output req_ready, dm_wr, dm_addr, dm_din, dm_loadsel, done, err
    );

endinterface

// File: rtl/store_merge.sv
// Combinational byte-lane merge of new store data into the old memory word.
module store_merge
    import store_rmw_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  sel,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    // Replace the addressed lane(s); everything else comes from old_word.
    always_comb begin
        merged = old_word;
        case (sel)
            SEL_SW: merged = new_data;
            SEL_SB: begin
                case (lane)
                    2'b00:   merged[7:0]   = new_data[7:0];
                    2'b01:   merged[15:8]  = new_data[7:0];
                    2'b10:   merged[23:16] = new_data[7:0];
                    2'b11:   merged[31:24] = new_data[7:0];
                    default: merged        = old_word;
                endcase
            end
            SEL_SH: begin
                if (lane[1]) begin
                    merged[31:16] = new_data[15:0];
                end else begin
                    merged[15:0]  = new_data[15:0];
                end
            end
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_rmw.sv
// Store unit doing read-modify-write for sb/sh and direct write for sw.
// Build option STORE_MISALIGN_TRAP_EN: reject sh with addr[0] set.
module store_rmw
    import store_rmw_pkg::*;
#(
    parameter int DM_WORDS = 128
) (
    input  logic       clk,
    input  logic       rstn,
    store_rmw_if.slave bus
);
    localparam int AW = $clog2(DM_WORDS);

    state_e        state_r;
    state_e        state_next_s;
    logic          accept_s;
    logic          reject_s;
    logic          start_s;
    logic          misalign_s;
    logic [1:0]    sel_r;
    logic [AW+1:0] addr_r;
    logic [31:0]   wdata_r;
    logic [31:0]   dm_din_r;
    logic [31:0]   merged_s;
    logic          req_ready_r;
    logic          dm_wr_r;
    logic          done_r;
    logic          err_r;

`ifdef STORE_MISALIGN_TRAP_EN
    assign misalign_s = (bus.req_sel == SEL_SH) && bus.req_addr[0];
`else
    assign misalign_s = 1'b0;
`endif

    // Handshake decode and next-state selection.
    always_comb begin
        accept_s     = bus.req_valid && (state_r == ST_IDLE);
        reject_s     = accept_s && ((bus.req_sel == SEL_RSV) || misalign_s);
        start_s      = accept_s && !reject_s;
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    if (sel_needs_read(bus.req_sel)) begin
                        state_next_s = ST_READ;
                    end else begin
                        state_next_s = ST_WRITE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ:  state_next_s = ST_WRITE;
            ST_WRITE: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    store_merge u_merge (
        .old_word (bus.dm_rdata),
        .new_data (wdata_r),
        .sel      (sel_r),
        .lane     (addr_r[1:0]),
        .merged   (merged_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request latches and registered outputs; rejected requests leave the memory-side registers untouched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel_r       <= 2'b00;
            addr_r      <= '0;
            wdata_r     <= 32'h0000_0000;
            dm_din_r    <= 32'h0000_0000;
            req_ready_r <= 1'b1;
            dm_wr_r     <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            req_ready_r <= (state_next_s == ST_IDLE);
            dm_wr_r     <= (state_next_s == ST_WRITE);
            done_r      <= (state_next_s == ST_WRITE) || reject_s;
            err_r       <= reject_s;
            if (start_s) begin
                sel_r   <= bus.req_sel;
                addr_r  <= bus.req_addr;
                wdata_r <= bus.req_wdata;
            end
            if (start_s && (bus.req_sel == SEL_SW)) begin
                dm_din_r <= bus.req_wdata;
            end else if (state_r == ST_READ) begin
                dm_din_r <= merged_s;
            end
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.dm_wr      = dm_wr_r;
    assign bus.dm_addr    = addr_r[AW+1:2];
    assign bus.dm_din     = dm_din_r;
    assign bus.dm_loadsel = LOADSEL_WORD;
    assign bus.done       = done_r;
    assign bus.err        = err_r;

endmodule

// File: tb/tb_store_rmw.sv
// Directed bench for store_rmw with a small word-addressed data memory.
module tb_store_rmw;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_err;

    logic [31:0] mem [0:127];
    logic        pl_en;
    logic [6:0]  pl_addr;
    logic [31:0] pl_data;

    store_rmw_if #(.DM_WORDS(128)) bus ();

    store_rmw #(.DM_WORDS(128)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.dm_rdata = mem[bus.dm_addr];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.dm_wr) begin
            mem[bus.dm_addr] <= bus.dm_din;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [6:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Issue one store from IDLE and check write latency, address, data and pulses.
    task automatic run_store(input string tag, input logic [1:0] sel, input logic [8:0] addr,
                             input logic [31:0] wd, input int exp_lat,
                             input logic [6:0] exp_addr, input logic [31:0] exp_din);
        int lat;
        bus.req_valid = 1'b1;
        bus.req_sel   = sel;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.dm_wr && lat < 4) begin
            chk({tag, "_rdaddr"}, 32'(bus.dm_addr), 32'(exp_addr));
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"},  32'(lat),         32'(exp_lat));
        chk({tag, "_addr"}, 32'(bus.dm_addr), 32'(exp_addr));
        chk({tag, "_din"},  bus.dm_din,       exp_din);
        chk({tag, "_done"}, 32'(bus.done),    32'd1);
        chk({tag, "_err"},  32'(bus.err),     32'd0);
        @(negedge clk);
        chk({tag, "_wroff"}, 32'(bus.dm_wr),     32'd0);
        chk({tag, "_rdy"},   32'(bus.req_ready), 32'd1);
        chk({tag, "_mem"},   mem[exp_addr],      exp_din);
    endtask

    initial begin
        logic [7:0] wr_mask;
        logic [7:0] rdy_mask;
        int         wr_cnt;
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b0;
        pl_en = 1'b0;
        pl_addr = 7'd0;
        pl_data = 32'h0000_0000;
        bus.req_valid = 1'b0;
        bus.req_sel   = 2'b00;
        bus.req_addr  = 9'h000;
        bus.req_wdata = 32'h0000_0000;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready",   32'(bus.req_ready),  32'd1);
        chk("rst_wr",      32'(bus.dm_wr),      32'd0);
        chk("rst_done",    32'(bus.done),       32'd0);
        chk("rst_err",     32'(bus.err),        32'd0);
        chk("rst_addr",    32'(bus.dm_addr),    32'd0);
        chk("rst_din",     bus.dm_din,          32'h0000_0000);
        chk("rst_loadsel", 32'(bus.dm_loadsel), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Sub-word merges into 0x11223344 at word 4
        preload(7'h04, 32'h1122_3344);
        run_store("sb012", 2'b01, 9'h012, 32'h0000_00AA, 2, 7'h04, 32'h11AA_3344);
        chk("sb012_hold", bus.dm_din, 32'h11AA_3344);
        preload(7'h04, 32'h1122_3344);
        run_store("sh012", 2'b10, 9'h012, 32'h0000_BEEF, 2, 7'h04, 32'hBEEF_3344);
        preload(7'h04, 32'h1122_3344);
        run_store("sh010", 2'b10, 9'h010, 32'h0000_BEEF, 2, 7'h04, 32'h1122_BEEF);
        preload(7'h04, 32'h1122_3344);
        run_store("sb013", 2'b01, 9'h013, 32'h0000_0055, 2, 7'h04, 32'h5522_3344);

        // Half-word store with addr[0] set
        preload(7'h04, 32'h1122_3344);
`ifdef STORE_MISALIGN_TRAP_EN
        bus.req_valid = 1'b1;
        bus.req_sel   = 2'b10;
        bus.req_addr  = 9'h011;
        bus.req_wdata = 32'h0000_CAFE;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("mis_err",  32'(bus.err),   32'd1);
        chk("mis_done", 32'(bus.done),  32'd1);
        chk("mis_wr",   32'(bus.dm_wr), 32'd0);
        wr_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_cnt += 32'(bus.dm_wr);
        end
        chk("mis_nowr", 32'(wr_cnt), 32'd0);
        chk("mis_mem",  mem[4],      32'h1122_3344);
`else
        run_store("sh011", 2'b10, 9'h011, 32'h0000_CAFE, 2, 7'h04, 32'h1122_CAFE);
`endif

        // Reserved select: error pulse only
        bus.req_valid = 1'b1;
        bus.req_sel   = 2'b11;
        bus.req_addr  = 9'h020;
        bus.req_wdata = 32'h1234_5678;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rsv_err",  32'(bus.err),       32'd1);
        chk("rsv_done", 32'(bus.done),      32'd1);
        chk("rsv_wr",   32'(bus.dm_wr),     32'd0);
        chk("rsv_rdy",  32'(bus.req_ready), 32'd1);
        @(negedge clk);
        chk("rsv_err_off", 32'(bus.err),  32'd0);
        chk("rsv_done_off", 32'(bus.done), 32'd0);
        chk("rsv_wr_off",   32'(bus.dm_wr), 32'd0);

        // Reset during READ aborts the store
        preload(7'h05, 32'h5566_7788);
        bus.req_valid = 1'b1;
        bus.req_sel   = 2'b01;
        bus.req_addr  = 9'h014;
        bus.req_wdata = 32'h0000_0099;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort_busy", 32'(bus.req_ready), 32'd0);
        rstn = 1'b0;
        #1;
        chk("abort_wr",  32'(bus.dm_wr),     32'd0);
        chk("abort_rdy", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        wr_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_cnt += 32'(bus.dm_wr);
        end
        chk("abort_nowr", 32'(wr_cnt), 32'd0);
        chk("abort_mem",  mem[5],      32'h5566_7788);
        chk("abort_rdy2", 32'(bus.req_ready), 32'd1);

        // Word store to the top word
        run_store("sw1fc", 2'b00, 9'h1FC, 32'hDEAD_BEEF, 1, 7'h7F, 32'hDEAD_BEEF);

        // Three back-to-back word stores with req_valid held high
        wr_mask  = 8'h00;
        rdy_mask = 8'h00;
        wr_cnt   = 0;
        bus.req_valid = 1'b1;
        bus.req_sel   = 2'b00;
        bus.req_addr  = 9'h040;
        bus.req_wdata = 32'h0101_0101;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            wr_mask[i-1]  = bus.dm_wr;
            rdy_mask[i-1] = bus.req_ready;
            wr_cnt += 32'(bus.dm_wr);
            if (i == 1) begin
                bus.req_addr  = 9'h044;
                bus.req_wdata = 32'h0202_0202;
            end
            if (i == 3) begin
                bus.req_addr  = 9'h048;
                bus.req_wdata = 32'h0303_0303;
            end
            if (i == 5) begin
                bus.req_valid = 1'b0;
            end
        end
        chk("b2b_wrmask",  32'(wr_mask),  32'h0000_0015);
        chk("b2b_rdymask", 32'(rdy_mask), 32'h0000_00EA);
        chk("b2b_count",   32'(wr_cnt),   32'd3);
        chk("b2b_mem0",    mem[16],       32'h0101_0101);
        chk("b2b_mem1",    mem[17],       32'h0202_0202);
        chk("b2b_mem2",    mem[18],       32'h0303_0303);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
